sti_receiver: RTL and testbench
===============================

# sti_receiver

Serial-to-parallel receiver for the STI serial link, the receive end of the `so_data`/`so_valid` stream produced by the STI transmitter. It collects one frame of 8/16/24/32 bits, MSB-first or LSB-first, into a right-aligned 32-bit word. It recovers the original 16-bit payload using the same length/fill/low controls the transmitter used, and flags frames that end early. It sits on the link between the transmitter and downstream consumers, such as a checker or memory writer.

## Interface
- No parameters; frame lengths are fixed at 8/16/24/32 bits.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `si_data` input 1: serial data bit; sampled only when `si_valid`=1.
- `si_valid` input 1: bit-valid qualifier; a frame is one contiguous run of `si_valid`=1.
- `cfg_load` input 1: latches `cfg_length`/`cfg_msb`/`cfg_fill`/`cfg_low`; honoured only in IDLE.
- `cfg_length` input 2: frame length, 0→8, 1→16, 2→24, 3→32 bits.
- `cfg_msb` input 1: 1 = first received bit is the MSB; 0 = first received bit is the LSB.
- `cfg_fill` input 1: 24/32-bit frames only. 1 = payload in the top 16 bits; 0 = payload in the bottom 16 bits.
- `cfg_low` input 1: 8-bit frames only. 1 = byte is `payload[15:8]`; 0 = byte is `payload[7:0]`.
- `po_data` output 32: received frame, right-aligned in `[N-1:0]`, upper bits 0. Held until the next frame completes.
- `po_payload` output 16: recovered payload. Held with `po_data`.
- `po_valid` output 1: one-cycle pulse when `po_data`/`po_payload` update.
- `po_err` output 1: one-cycle pulse when a frame is truncated.
- `busy` output 1: 1 while in RECV.
- `frame_cnt` output 8: count of good frames; wraps 255→0.

## Operation
- States: IDLE, RECV.
- IDLE:
  - `cfg_load`=1 latches all four cfg inputs.
  - `si_valid`=1 captures bit 1 and moves to RECV with `bit_cnt`=1.
  - If `cfg_load` and `si_valid` are both 1 in the same cycle, the new config governs that frame.
- RECV, `si_valid`=1:
  - Capture the bit and increment `bit_cnt`.
  - When the captured bit is bit N: register the outputs, reset `bit_cnt`, and return to IDLE.
  - If `si_valid` is still 1 next cycle, that bit starts a new frame, so back-to-back frames need no gap.
- RECV, `si_valid`=0 with `bit_cnt`<N: pulse `po_err`, discard the partial frame, go to IDLE. `po_data`, `po_payload` and `frame_cnt` are unchanged.
- `cfg_load` in RECV is ignored; the latched config is unchanged.
- Bit assembly:
  - `cfg_msb`=1: shift register `sh = {sh[30:0], si_data}`.
  - `cfg_msb`=0: `sh[bit_cnt] = si_data`, where `bit_cnt` is 0-based.
  - The shift register is cleared at frame start so unused upper bits are 0.
- Payload recovery, N = frame length:
  - N=8: `cfg_low` ? `{byte, 8'h00}` : `{8'h00, byte}`.
  - N=16: `po_data[15:0]`.
  - N=24/32: `cfg_fill` ? `po_data[N-1:N-16]` : `po_data[15:0]`.
- `frame_cnt` increments by one per `po_valid`; 8-bit modulo-256 arithmetic.

## Timing
- Reset values: all outputs 0; state IDLE; `bit_cnt`=0; cfg registers 0 (8-bit, LSB-first, fill=0, low=0).
- Latency: `po_valid` is high in the cycle after the edge that samples bit N. `po_data`/`po_payload` are valid in that same cycle and held afterwards.
- `po_err` is high in the cycle after the edge that samples `si_valid`=0 in RECV.
- `busy` is 1 from the cycle after the first bit is sampled until the cycle after bit N or the abort.
- `po_valid` and `po_err` are never high together.
- Minimum frame spacing is 0 cycles; sustained throughput is one bit per clock.
- `reset` asserted mid-frame: immediate return to reset values; the partial frame is lost with no `po_err`.

## Test plan
- Frame: cfg len=0, msb=1, low=0; bits 1,0,1,0,0,1,0,1 → `po_valid` 1 cycle after bit 8; `po_data`=0x000000A5; `po_payload`=0x00A5; `frame_cnt`=1.
- Frame: cfg len=1, msb=0; 0x1234 sent LSB-first (0,0,1,0,1,1,0,0,0,1,0,0,1,0,0,0) → `po_data`=0x00001234; `po_payload`=0x1234.
- Frames: len=2, msb=1, fill=1, 0x123400 → `po_payload`=0x1234. Then len=3, fill=0, 0x00005678 → `po_payload`=0x5678; `po_data`=0x00005678.
- Truncation: len=1; `si_valid` high for 10 bits then low → `po_err` pulse; no `po_valid`; `po_data` and `frame_cnt` unchanged.
- Back-to-back: len=0; `si_valid` high for 16 cycles carrying 0x3C then 0xC3 → two `po_valid` pulses 8 cycles apart with `po_data` 0x3C then 0xC3. Asserting `cfg_load` (len=3) mid-frame has no effect.
- Reset/wrap: `reset` asserted after 5 bits → all outputs 0 with no `po_err`. Then 256 good 8-bit frames → `frame_cnt` wraps to 0.

Source files
------------

// File: rtl/sti_receiver.sv
// sti_receiver: serial-to-parallel receiver for the STI link.
// Collects one frame of 8/16/24/32 bits, MSB- or LSB-first, into a
// right-aligned 32-bit word and recovers the 16-bit payload using the
// same length/fill/low controls the transmitter used.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   si_data, si_valid serial bit and its qualifier (one frame = one run of valid)
//   cfg_load          latch cfg_* (honoured only while idle)
//   cfg_length        0/1/2/3 -> 8/16/24/32-bit frame
//   cfg_msb           1 = first bit is MSB, 0 = first bit is LSB
//   cfg_fill          24/32-bit frames: 1 = payload in top 16 bits
//   cfg_low           8-bit frames: 1 = byte is payload[15:8]
//   po_data           last good frame, right-aligned, upper bits 0
//   po_payload        recovered payload of the last good frame
//   po_valid          one-cycle pulse when po_data/po_payload update
//   po_err            one-cycle pulse when a frame is truncated
//   busy              1 while a frame is being received
//   frame_cnt         good-frame count, wraps 255 -> 0
module sti_receiver (
  input  logic        clk,
  input  logic        reset,
  input  logic        si_data,
  input  logic        si_valid,
  input  logic        cfg_load,
  input  logic [1:0]  cfg_length,
  input  logic        cfg_msb,
  input  logic        cfg_fill,
  input  logic        cfg_low,
  output logic [31:0] po_data,
  output logic [15:0] po_payload,
  output logic        po_valid,
  output logic        po_err,
  output logic        busy,
  output logic [7:0]  frame_cnt
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned PAY_W  = 16;
  localparam int unsigned CNT_W  = 6;
  localparam int unsigned FC_W   = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  state_t              state, state_nx;
  logic [CNT_W-1:0]    bit_cnt, bit_cnt_nx;
  logic [DATA_W-1:0]   sh, sh_nx;
  logic [1:0]          len_q, len_nx;
  logic                msb_q, msb_nx;
  logic                fill_q, fill_nx;
  logic                low_q, low_nx;
  logic [DATA_W-1:0]   po_data_nx;
  logic [PAY_W-1:0]    po_payload_nx;
  logic                po_valid_nx;
  logic                po_err_nx;
  logic                busy_nx;
  logic [FC_W-1:0]     frame_cnt_nx;

  // Effective configuration: a cfg_load in the same idle cycle as the first
  // bit already governs that frame.
  logic [1:0]          len_e;
  logic                msb_e;
  logic                fill_e;
  logic                low_e;
  logic [DATA_W-1:0]   sh_base;
  logic [DATA_W-1:0]   sh_cap;
  logic [CNT_W-1:0]    cnt_cap;
  logic [CNT_W-1:0]    n_bits;

  // Frame length in bits for a length code.
  function automatic logic [CNT_W-1:0] frame_bits(input logic [1:0] len);
    logic [CNT_W-1:0] n;
    case (len)
      2'd0:    n = CNT_W'(8);
      2'd1:    n = CNT_W'(16);
      2'd2:    n = CNT_W'(24);
      default: n = CNT_W'(32);
    endcase
    return n;
  endfunction

  // Payload recovery from a right-aligned frame word.
  function automatic logic [PAY_W-1:0] recover(input logic [1:0]        len,
                                               input logic              fill,
                                               input logic              low,
                                               input logic [DATA_W-1:0] w);
    logic [PAY_W-1:0] p;
    case (len)
      2'd0:    p = low ? {w[7:0], 8'h00} : {8'h00, w[7:0]};
      2'd1:    p = w[15:0];
      2'd2:    p = fill ? w[23:8] : w[15:0];
      default: p = fill ? w[31:16] : w[15:0];
    endcase
    return p;
  endfunction

  // Bit capture datapath: shift register is cleared at frame start.
  always_comb begin
    len_e   = len_q;
    msb_e   = msb_q;
    fill_e  = fill_q;
    low_e   = low_q;
    if (state == IDLE && cfg_load) begin
      len_e  = cfg_length;
      msb_e  = cfg_msb;
      fill_e = cfg_fill;
      low_e  = cfg_low;
    end
    sh_base = (state == IDLE) ? '0 : sh;
    if (msb_e) begin
      sh_cap = {sh_base[DATA_W-2:0], si_data};
    end else begin
      sh_cap = sh_base;
      sh_cap[(state == IDLE) ? 5'd0 : bit_cnt[4:0]] = si_data;
    end
    cnt_cap = (state == IDLE) ? CNT_W'(1) : bit_cnt + CNT_W'(1);
    n_bits  = frame_bits(len_e);
  end

  // Next-state and output logic.
  always_comb begin
    state_nx      = state;
    bit_cnt_nx    = bit_cnt;
    sh_nx         = sh;
    len_nx        = len_q;
    msb_nx        = msb_q;
    fill_nx       = fill_q;
    low_nx        = low_q;
    po_data_nx    = po_data;
    po_payload_nx = po_payload;
    po_valid_nx   = 1'b0;
    po_err_nx     = 1'b0;
    frame_cnt_nx  = frame_cnt;

    case (state)
      IDLE: begin
        if (cfg_load) begin
          len_nx  = cfg_length;
          msb_nx  = cfg_msb;
          fill_nx = cfg_fill;
          low_nx  = cfg_low;
        end
        // Shortest frame is 8 bits, so the first bit never completes one.
        if (si_valid) begin
          sh_nx      = sh_cap;
          bit_cnt_nx = cnt_cap;
          state_nx   = RECV;
        end
      end
      RECV: begin
        if (si_valid) begin
          sh_nx = sh_cap;
          if (cnt_cap == n_bits) begin
            po_data_nx    = sh_cap;
            po_payload_nx = recover(len_e, fill_e, low_e, sh_cap);
            po_valid_nx   = 1'b1;
            frame_cnt_nx  = frame_cnt + FC_W'(1);
            bit_cnt_nx    = '0;
            state_nx      = IDLE;
          end else begin
            bit_cnt_nx = cnt_cap;
          end
        end else begin
          // Truncated frame: drop it, keep the last good outputs.
          po_err_nx  = 1'b1;
          bit_cnt_nx = '0;
          sh_nx      = '0;
          state_nx   = IDLE;
        end
      end
      default: begin
        state_nx   = IDLE;
        bit_cnt_nx = '0;
      end
    endcase

    busy_nx = (state_nx == RECV);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      sh         <= '0;
      len_q      <= '0;
      msb_q      <= 1'b0;
      fill_q     <= 1'b0;
      low_q      <= 1'b0;
      po_data    <= '0;
      po_payload <= '0;
      po_valid   <= 1'b0;
      po_err     <= 1'b0;
      busy       <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      state      <= state_nx;
      bit_cnt    <= bit_cnt_nx;
      sh         <= sh_nx;
      len_q      <= len_nx;
      msb_q      <= msb_nx;
      fill_q     <= fill_nx;
      low_q      <= low_nx;
      po_data    <= po_data_nx;
      po_payload <= po_payload_nx;
      po_valid   <= po_valid_nx;
      po_err     <= po_err_nx;
      busy       <= busy_nx;
      frame_cnt  <= frame_cnt_nx;
    end
  end

endmodule

// File: tb/tb_sti_receiver.sv
// tb_sti_receiver: directed bench for sti_receiver with a bit-list model
// checked every cycle plus hand-computed literal expectations.
module tb_sti_receiver;

  logic        clk;
  logic        reset;
  logic        si_data;
  logic        si_valid;
  logic        cfg_load;
  logic [1:0]  cfg_length;
  logic        cfg_msb;
  logic        cfg_fill;
  logic        cfg_low;
  logic [31:0] po_data;
  logic [15:0] po_payload;
  logic        po_valid;
  logic        po_err;
  logic        busy;
  logic [7:0]  frame_cnt;

  int tests = 0;
  int fails = 0;

  sti_receiver dut (
    .clk        (clk),
    .reset      (reset),
    .si_data    (si_data),
    .si_valid   (si_valid),
    .cfg_load   (cfg_load),
    .cfg_length (cfg_length),
    .cfg_msb    (cfg_msb),
    .cfg_fill   (cfg_fill),
    .cfg_low    (cfg_low),
    .po_data    (po_data),
    .po_payload (po_payload),
    .po_valid   (po_valid),
    .po_err     (po_err),
    .busy       (busy),
    .frame_cnt  (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: collect frame bits in a list, build the word arithmetically once
  // the list holds N bits.
  logic        m_valid = 1'b0;
  logic        m_err   = 1'b0;
  logic        m_busy  = 1'b0;
  logic [31:0] m_data  = '0;
  logic [15:0] m_pay   = '0;
  int          m_cnt   = 0;
  int          m_len   = 0;
  bit          m_msb   = 1'b0;
  bit          m_fill  = 1'b0;
  bit          m_low   = 1'b0;
  bit          m_in    = 1'b0;
  bit          m_bits[$];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid = 1'b0; m_err = 1'b0; m_busy = 1'b0;
      m_data = '0; m_pay = '0; m_cnt = 0;
      m_len = 0; m_msb = 1'b0; m_fill = 1'b0; m_low = 1'b0;
      m_in = 1'b0; m_bits.delete();
    end else begin
      m_valid = 1'b0;
      m_err   = 1'b0;
      if (!m_in) begin
        if (cfg_load) begin
          m_len = int'(cfg_length); m_msb = cfg_msb; m_fill = cfg_fill; m_low = cfg_low;
        end
        if (si_valid) begin
          m_bits.delete();
          m_bits.push_back(si_data);
          m_in = 1'b1;
        end
      end else if (si_valid) begin
        int n;
        m_bits.push_back(si_data);
        n = 8 * (m_len + 1);
        if (m_bits.size() == n) begin
          logic [31:0] val;
          val = '0;
          for (int i = 0; i < n; i++)
            val = val | (32'(m_bits[i]) << (m_msb ? (n - 1 - i) : i));
          m_data = val;
          if (n == 8)       m_pay = m_low ? 16'(val << 8) : 16'(val);
          else if (n == 16) m_pay = 16'(val);
          else              m_pay = m_fill ? 16'(val >> (n - 16)) : 16'(val);
          m_valid = 1'b1;
          m_cnt   = (m_cnt + 1) % 256;
          m_in    = 1'b0;
        end
      end else begin
        m_err = 1'b1;
        m_in  = 1'b0;
      end
      m_busy = m_in;
    end
  end

  // Per-cycle compare against the model; also logs po_valid pulses.
  int          cyc = 0;
  bit          log_en = 1'b0;
  int          vcyc[$];
  logic [31:0] vdat[$];

  always @(negedge clk) begin
    cyc++;
    chk("po_valid",   32'(po_valid),   32'(m_valid));
    chk("po_err",     32'(po_err),     32'(m_err));
    chk("busy",       32'(busy),       32'(m_busy));
    chk("po_data",    po_data,         m_data);
    chk("po_payload", 32'(po_payload), 32'(m_pay));
    chk("frame_cnt",  32'(frame_cnt),  32'(m_cnt));
    if (log_en && po_valid) begin
      vcyc.push_back(cyc);
      vdat.push_back(po_data);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_cfg(input logic [1:0] len, input logic msb, input logic fill, input logic low);
    cfg_length = len; cfg_msb = msb; cfg_fill = fill; cfg_low = low;
    cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
  endtask

  // Sends n bits of v in the given order; si_valid is left high.
  task automatic send_bits(input logic [31:0] v, input int n, input bit msb);
    for (int i = 0; i < n; i++) begin
      si_valid = 1'b1;
      si_data  = msb ? v[n - 1 - i] : v[i];
      step();
    end
  endtask

  initial begin
    logic [15:0] w;
    reset = 1'b1; si_data = 1'b0; si_valid = 1'b0; cfg_load = 1'b0;
    cfg_length = 2'd0; cfg_msb = 1'b0; cfg_fill = 1'b0; cfg_low = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_po_data", po_data, 32'h0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'h0);
    step();
    reset = 1'b0;
    step();

    // 8-bit MSB-first 0xA5
    load_cfg(2'd0, 1'b1, 1'b0, 1'b0);
    send_bits(32'hA5, 8, 1'b1);
    si_valid = 1'b0;
    @(negedge clk);
    chk("a5_valid", 32'(po_valid), 32'h1);
    chk("a5_data", po_data, 32'h000000A5);
    chk("a5_payload", 32'(po_payload), 32'h00A5);
    chk("a5_cnt", 32'(frame_cnt), 32'h1);
    step();

    // 16-bit LSB-first 0x1234
    load_cfg(2'd1, 1'b0, 1'b0, 1'b0);
    send_bits(32'h1234, 16, 1'b0);
    si_valid = 1'b0;
    @(negedge clk);
    chk("x1234_data", po_data, 32'h00001234);
    chk("x1234_payload", 32'(po_payload), 32'h1234);
    step();

    // 24-bit fill=1, then 32-bit fill=0
    load_cfg(2'd2, 1'b1, 1'b1, 1'b0);
    send_bits(32'h123400, 24, 1'b1);
    si_valid = 1'b0;
    @(negedge clk);
    chk("f24_data", po_data, 32'h00123400);
    chk("f24_payload", 32'(po_payload), 32'h1234);
    step();
    load_cfg(2'd3, 1'b1, 1'b0, 1'b0);
    send_bits(32'h00005678, 32, 1'b1);
    si_valid = 1'b0;
    @(negedge clk);
    chk("f32_data", po_data, 32'h00005678);
    chk("f32_payload", 32'(po_payload), 32'h5678);
    chk("f32_cnt", 32'(frame_cnt), 32'h4);
    step();

    // 8-bit with low=1 and LSB-first
    load_cfg(2'd0, 1'b0, 1'b0, 1'b1);
    send_bits(32'h5A, 8, 1'b0);
    si_valid = 1'b0;
    @(negedge clk);
    chk("low_payload", 32'(po_payload), 32'h5A00);
    step();

    // Truncation: 10 bits of a 16-bit frame
    load_cfg(2'd1, 1'b0, 1'b0, 1'b0);
    send_bits(32'h3FF, 10, 1'b0);
    si_valid = 1'b0;
    @(negedge clk);
    chk("trunc_no_err_yet", 32'(po_err), 32'h0);
    step();
    @(negedge clk);
    chk("trunc_err", 32'(po_err), 32'h1);
    chk("trunc_valid", 32'(po_valid), 32'h0);
    chk("trunc_data", po_data, 32'h0000005A);
    chk("trunc_cnt", 32'(frame_cnt), 32'h5);
    step();

    // Back-to-back 8-bit frames with cfg_load mid-frame
    load_cfg(2'd0, 1'b1, 1'b0, 1'b0);
    vcyc.delete(); vdat.delete();
    log_en = 1'b1;
    w = 16'h3CC3;
    for (int i = 0; i < 16; i++) begin
      si_valid = 1'b1;
      si_data  = w[15 - i];
      cfg_load = (i == 3);
      cfg_length = (i == 3) ? 2'd3 : 2'd0;
      step();
    end
    si_valid = 1'b0; cfg_load = 1'b0; cfg_length = 2'd0;
    step();
    log_en = 1'b0;
    chk("b2b_pulses", 32'(vcyc.size()), 32'h2);
    if (vcyc.size() == 2) begin
      chk("b2b_first", vdat[0], 32'h3C);
      chk("b2b_second", vdat[1], 32'hC3);
      chk("b2b_spacing", 32'(vcyc[1] - vcyc[0]), 32'h8);
    end
    step();

    // Reset after 5 bits of a frame
    send_bits(32'h1F, 5, 1'b1);
    reset = 1'b1; si_valid = 1'b0;
    @(negedge clk);
    chk("mid_rst_err", 32'(po_err), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_data", po_data, 32'h0);
    chk("mid_rst_cnt", 32'(frame_cnt), 32'h0);
    step();
    reset = 1'b0;
    step();

    // 256 back-to-back 8-bit LSB-first frames: counter wraps to 0
    for (int f = 0; f < 256; f++) begin
      send_bits(32'(f), 8, 1'b0);
      if (f == 254) begin
        @(negedge clk);
        chk("cnt_255", 32'(frame_cnt), 32'hFF);
      end
    end
    si_valid = 1'b0;
    @(negedge clk);
    chk("wrap_valid", 32'(po_valid), 32'h1);
    chk("wrap_cnt", 32'(frame_cnt), 32'h0);
    chk("wrap_data", po_data, 32'h000000FF);
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
